// File: rtl/pbus_irq_gateway_if.sv
// rtl/pbus_irq_gateway_if.sv - PLIC-side claim/complete handshake and request bundle
interface pbus_irq_gateway_if;
   logic        claim_valid_i;
   logic [4:0]  claim_id_i;
   logic        complete_valid_i;
   logic [4:0]  complete_id_i;
   logic [31:0] plic_req_o;
   logic [31:0] overflow_o;

   modport master (
      output claim_valid_i, claim_id_i, complete_valid_i, complete_id_i,
      input  plic_req_o, overflow_o
   );

   modport slave (
      input  claim_valid_i, claim_id_i, complete_valid_i, complete_id_i,
      output plic_req_o, overflow_o
   );
endinterface

// File: rtl/pbus_irq_gateway.sv
// rtl/pbus_irq_gateway.sv - PLIC gateway for four peripheral bus interrupts
// Lines 1..4 are fed by pbus_irq_i[0..3]; every other PLIC line is tied idle.
module pbus_irq_gateway #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] EDGE_MASK   = 32'h0,
   parameter int          CNT_W       = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [3:0]        pbus_irq_i,
   pbus_irq_gateway_if.slave plic
);
   typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, CLAIMED = 2'd2} line_state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [3:0]       sync_q [SYNC_STAGES];
   logic [3:0]       hist_q;
   logic [3:0]       level;
   logic [3:0]       rise;
   logic [3:0]       claim_hit;
   logic [3:0]       comp_hit;
   logic [3:0]       cnt_rise;
   logic [3:0]       cnt_sat;
   logic [3:0]       ovf_q;
   line_state_e      state_q [4];
   logic [CNT_W-1:0] cnt_q   [4];
   logic [CNT_W-1:0] cnt_eff [4];

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~hist_q;

   // cnt_eff already includes a rise arriving this cycle, so a completion
   // coinciding with a new edge still sees that edge.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         claim_hit[i] = plic.claim_valid_i && (plic.claim_id_i == 5'(i + 1));
         comp_hit[i]  = plic.complete_valid_i && (plic.complete_id_i == 5'(i + 1));
         cnt_rise[i]  = EDGE_MASK[i + 1] && rise[i] && (state_q[i] != IDLE);
         cnt_sat[i]   = (cnt_q[i] == CNT_MAX);
         cnt_eff[i]   = (cnt_rise[i] && !cnt_sat[i]) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      end
   end

   always_comb begin
      plic.plic_req_o = '0;
      plic.overflow_o = '0;
      for (int i = 0; i < 4; i++) begin
         plic.plic_req_o[i + 1] = (state_q[i] == PENDING);
         plic.overflow_o[i + 1] = ovf_q[i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         hist_q <= '0;
         ovf_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync_q[0] <= pbus_irq_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         hist_q <= level;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_eff[i];
            if (cnt_rise[i] && cnt_sat[i]) ovf_q[i] <= 1'b1;
            case (state_q[i])
               IDLE: begin
                  if (EDGE_MASK[i + 1] ? rise[i] : level[i]) state_q[i] <= PENDING;
               end
               PENDING: begin
                  if (claim_hit[i])                          state_q[i] <= CLAIMED;
                  else if (!EDGE_MASK[i + 1] && !level[i])   state_q[i] <= IDLE;
               end
               CLAIMED: begin
                  if (comp_hit[i]) begin
                     if (EDGE_MASK[i + 1]) begin
                        if (cnt_eff[i] != '0) begin
                           state_q[i] <= PENDING;
                           cnt_q[i]   <= cnt_eff[i] - CNT_W'(1);
                        end else begin
                           state_q[i] <= IDLE;
                        end
                     end else begin
                        state_q[i] <= level[i] ? PENDING : IDLE;
                     end
                  end
               end
               default: state_q[i] <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pbus_irq_gateway.sv
// tb/tb_pbus_irq_gateway.sv - scoreboard bench for pbus_irq_gateway
module tb_pbus_irq_gateway;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] irq = 4'h0;

   pbus_irq_gateway_if bus ();

   pbus_irq_gateway #(
      .SYNC_STAGES (2),
      .EDGE_MASK   (32'h4),
      .CNT_W       (4)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .pbus_irq_i (irq),
      .plic       (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] req;
      logic [31:0] ovf;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_run  = 0;
   int   n_fail = 0;
   bit   done   = 1'b0;

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         cur = sb.pop_front();
         n_run++;
         if (bus.plic_req_o !== cur.req || bus.overflow_o !== cur.ovf) begin
            n_fail++;
            $display("FAIL %s: req=%h ovf=%h, expected req=%h ovf=%h",
                     cur.name, bus.plic_req_o, bus.overflow_o, cur.req, cur.ovf);
         end
      end
   end

   initial begin
      #100000;
      if (!done) begin
         n_fail++;
         $display("FAIL timeout: bench did not finish within the wait limit");
         $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
         $finish;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] req, input logic [31:0] ovf);
      exp_t e;
      e.name = name;
      e.req  = req;
      e.ovf  = ovf;
      sb.push_back(e);
   endtask

   task automatic chk_now(input string name, input logic [31:0] req, input logic [31:0] ovf);
      n_run++;
      if (bus.plic_req_o !== req || bus.overflow_o !== ovf) begin
         n_fail++;
         $display("FAIL %s: req=%h ovf=%h, expected req=%h ovf=%h",
                  name, bus.plic_req_o, bus.overflow_o, req, ovf);
      end
   endtask

   task automatic handshake(input logic cv, input logic [4:0] cid,
                            input logic pv, input logic [4:0] pid);
      bus.claim_valid_i    = cv;
      bus.claim_id_i       = cid;
      bus.complete_valid_i = pv;
      bus.complete_id_i    = pid;
      tick(1);
      bus.claim_valid_i    = 1'b0;
      bus.complete_valid_i = 1'b0;
   endtask

   task automatic claim(input logic [4:0] id);
      handshake(1'b1, id, 1'b0, 5'd0);
   endtask

   task automatic complete(input logic [4:0] id);
      handshake(1'b0, 5'd0, 1'b1, id);
   endtask

   task automatic pulse(input int b);
      irq[b] = 1'b1;
      tick(1);
      irq[b] = 1'b0;
      tick(1);
   endtask

   initial begin
      bus.claim_valid_i    = 1'b0;
      bus.claim_id_i       = 5'd0;
      bus.complete_valid_i = 1'b0;
      bus.complete_id_i    = 5'd0;

      tick(2);
      chk_now("reset_state", 32'h0, 32'h0);
      rst_n = 1'b1;
      tick(2);
      chk("idle_after_reset", 32'h0, 32'h0);

      irq[3] = 1'b1;
      tick(2);
      chk("uart_edge2", 32'h0, 32'h0);
      tick(1);
      chk("uart_edge3", 32'h10, 32'h0);
      claim(5'd0);
      chk("claim_id0_ignored", 32'h10, 32'h0);
      claim(5'd7);
      chk("claim_id7_ignored", 32'h10, 32'h0);
      complete(5'd2);
      chk("complete_id2_ignored", 32'h10, 32'h0);
      complete(5'd4);
      chk("complete_pending_ignored", 32'h10, 32'h0);
      claim(5'd4);
      chk("uart_claimed", 32'h0, 32'h0);
      tick(2);
      chk("uart_claimed_hold", 32'h0, 32'h0);
      complete(5'd4);
      chk("uart_rerequest", 32'h10, 32'h0);
      irq[3] = 1'b0;
      tick(3);
      chk("uart_level_drop", 32'h0, 32'h0);

      pulse(1);
      tick(1);
      chk("t0_first_edge", 32'h4, 32'h0);
      claim(5'd2);
      chk("t0_claimed", 32'h0, 32'h0);
      pulse(1);
      pulse(1);
      pulse(1);
      tick(2);
      chk("t0_three_queued", 32'h0, 32'h0);
      complete(5'd2);
      chk("t0_round1", 32'h4, 32'h0);
      claim(5'd2);
      complete(5'd2);
      chk("t0_round2", 32'h4, 32'h0);
      claim(5'd2);
      complete(5'd2);
      chk("t0_round3", 32'h4, 32'h0);
      claim(5'd2);
      chk("t0_last_claim", 32'h0, 32'h0);
      complete(5'd2);
      chk("t0_idle", 32'h0, 32'h0);

      irq[0] = 1'b1;
      irq[2] = 1'b1;
      tick(3);
      chk("l1_l3_pending", 32'h0A, 32'h0);
      claim(5'd3);
      chk("l3_claimed", 32'h02, 32'h0);
      handshake(1'b1, 5'd1, 1'b1, 5'd3);
      chk("claim1_complete3", 32'h08, 32'h0);
      irq[2] = 1'b0;
      tick(3);
      chk("l3_drop", 32'h0, 32'h0);
      complete(5'd1);
      chk("l1_rerequest", 32'h02, 32'h0);
      irq[0] = 1'b0;
      tick(3);
      chk("l1_drop", 32'h0, 32'h0);

      pulse(1);
      tick(1);
      chk("ovf_pending", 32'h4, 32'h0);
      claim(5'd2);
      for (int k = 0; k < 15; k++) pulse(1);
      tick(2);
      chk("cnt_15_no_ovf", 32'h0, 32'h0);
      pulse(1);
      tick(2);
      chk("cnt_16th_ovf", 32'h0, 32'h4);
      complete(5'd2);
      chk("ovf_sticky", 32'h4, 32'h4);

      irq[3] = 1'b1;
      tick(3);
      chk("uart_again", 32'h14, 32'h4);
      claim(5'd4);
      chk("uart_claimed_again", 32'h4, 32'h4);
      @(negedge clk);
      #1;
      irq[1] = 1'b1;
      rst_n  = 1'b0;
      #1;
      chk_now("async_reset", 32'h0, 32'h0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("post_reset_edge2", 32'h0, 32'h0);
      tick(1);
      chk("post_reset_edge3", 32'h14, 32'h0);

      tick(1);
      @(negedge clk);
      #1;
      wait (sb.size() == 0);
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/pbus_irq_gateway.md
PBUS_IRQ_GATEWAY -- requirements
Module: pbus_irq_gateway

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchroniser flops (legal range 2..4).
REQ-002 SHALL have parameter EDGE_MASK, default 32'h0, per PLIC line: 1 = edge-triggered, 0 = level-triggered.
REQ-003 SHALL have parameter CNT_W, default 4, width of per-line saturating edge counter.
REQ-004 SHALL have port clk_i  in  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port pbus_irq_i  in  4  raw peripheral bus interrupts, asynchronous to clk_i.
REQ-007 SHALL have port claim_valid_i  in  1  PLIC claims the line given by claim_id_i this cycle.
REQ-008 SHALL have port claim_id_i  in  5  claimed PLIC line ID.
REQ-009 SHALL have port complete_valid_i  in  1  PLIC signals completion for complete_id_i this cycle.
REQ-010 SHALL have port complete_id_i  in  5  completed PLIC line ID.
REQ-011 SHALL have port plic_req_o  out  32  per-line interrupt request to the PLIC.
REQ-012 SHALL have port overflow_o  out  32  sticky per-line edge-counter overflow flag.

Function
REQ-013 Fixed mapping: pbus_irq_i[0] GPIO-in -> line 1; [1] Timer 0 -> line 2; [2] Timer 1 -> line 3; [3] UART -> line 4.
REQ-014 Line 0 (reserved) and lines 5..31 SHALL stay IDLE with plic_req_o bit and overflow_o bit 0 at all times.
REQ-015 Each pbus_irq_i bit SHALL pass through SYNC_STAGES flops, then one history flop for edge detection (rise = sync & ~hist).
REQ-016 Per mapped line, state machine IDLE, PENDING, CLAIMED; plic_req_o[n] = 1 iff state is PENDING.
REQ-017 Level line: IDLE -> PENDING when synced level = 1; PENDING -> IDLE when synced level = 0 and no claim that cycle.
REQ-018 Edge line: IDLE -> PENDING on a detected rise; rises in PENDING or CLAIMED increment cnt (saturating at 2^CNT_W-1).
REQ-019 A rise arriving while cnt is saturated SHALL set overflow_o[n]; cleared only by reset.
REQ-020 PENDING -> CLAIMED when claim_valid_i and claim_id_i = n; claim for a line not PENDING, or for ID 0, SHALL be ignored.
REQ-021 CLAIMED -> next state on complete_valid_i and complete_id_i = n; complete for a line not CLAIMED SHALL be ignored.
REQ-022 On completion, level line: PENDING if synced level = 1, else IDLE; edge line: PENDING with cnt decremented if cnt (including a same-cycle rise) > 0, else IDLE.
REQ-023 Claim and complete in the same cycle SHALL both be applied when IDs differ; with equal IDs at most one can match the line state and only that one applies.
REQ-024 Latency: a clean 0->1 on pbus_irq_i SHALL raise plic_req_o on the (SYNC_STAGES+1)th rising clk_i edge after the change.
REQ-025 plic_req_o SHALL fall in the cycle after the matching claim is sampled.
REQ-026 Lines SHALL be independent; simultaneous events on different lines SHALL not interact.

Reset
REQ-027 On rst_ni = 0: all synchroniser and history flops, states, counters and overflow_o cleared, all lines IDLE, plic_req_o = 0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL discard all pending and claimed state; after release a still-high level input re-requests with REQ-024 latency.
REQ-029 History flop reset to 0: a line high when reset releases SHALL count as a rise for edge lines.

Verification
REQ-030 Level UART: pbus_irq_i[3] 0->1 -> plic_req_o = 32'h10 on 3rd edge; claim ID 4 -> 0 next cycle; complete ID 4 with input high -> 32'h10 again.
REQ-031 Edge Timer 0 (EDGE_MASK = 32'h4): 3 pulses while CLAIMED -> cnt = 3; three claim/complete rounds each re-raise bit 2; fourth complete -> IDLE.
REQ-032 Edge overflow, CNT_W = 4: 16 rises while CLAIMED -> cnt = 15, overflow_o = 32'h4, sticky until reset.
REQ-033 Illegal handshakes: claim ID 0, claim ID 7, complete ID 2 while PENDING -> no state or output change.
REQ-034 Simultaneous: claim ID 1 and complete ID 3 same cycle with both lines eligible -> line 1 CLAIMED, line 3 re-evaluated per REQ-022.
REQ-035 Reset mid-CLAIMED with input high: rst_ni low -> plic_req_o = 0 immediately; after release request reappears on 3rd edge.
